// File: rtl/placar_bcd.sv
// rtl/placar_bcd.sv - two-digit BCD scoreboard with debounced inc/dec push buttons
module placar_bcd #(
    parameter int DEBOUNCE_CICLOS = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       zerar,
    output logic [7:0] saida,
    output logic       estouro
);

    // Counter only has to reach DEBOUNCE_CICLOS-1, so clog2 bits are enough.
    localparam int             CW      = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    // Index 0 is the increment button, index 1 the decrement button.
    logic [1:0]    w_btn;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_q;
    logic [1:0]    r_evt;
    logic [CW-1:0] r_cnt [0:1];

    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic          r_estouro;

    logic          w_do_inc;
    logic          w_do_dec;
    logic [3:0]    w_units_nx;
    logic [3:0]    w_tens_nx;
    logic          w_wrap;

    assign w_btn = {btn_dec_n, btn_inc_n};

    // Two-flop synchronizers; idle level is 1 (button released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncers: the stable level follows only after DEBOUNCE_CICLOS consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press events: registered one-cycle pulse on a 1->0 transition of the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_q <= 2'b11;
            r_evt      <= 2'b00;
        end else begin
            r_stable_q <= r_stable;
            r_evt      <= r_stable_q & ~r_stable;
        end
    end

    // Simultaneous increment and decrement events cancel each other.
    assign w_do_inc = r_evt[0] & ~r_evt[1];
    assign w_do_dec = r_evt[1] & ~r_evt[0];

    // Next BCD value: carry/borrow between digits, wrap on 99, saturate at 00.
    always_comb begin
        w_units_nx = r_units;
        w_tens_nx  = r_tens;
        w_wrap     = 1'b0;
        if (w_do_inc) begin
            if (r_units < 4'd9) begin
                w_units_nx = r_units + 4'd1;
            end else if (r_tens < 4'd9) begin
                w_units_nx = 4'd0;
                w_tens_nx  = r_tens + 4'd1;
            end else begin
                w_units_nx = 4'd0;
                w_tens_nx  = 4'd0;
                w_wrap     = 1'b1;
            end
        end else if (w_do_dec) begin
            if (r_units > 4'd0) begin
                w_units_nx = r_units - 4'd1;
            end else if (r_tens > 4'd0) begin
                w_units_nx = 4'd9;
                w_tens_nx  = r_tens - 4'd1;
            end
        end
    end

    // Score register; zerar overrides any event arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_units   <= 4'd0;
            r_tens    <= 4'd0;
            r_estouro <= 1'b0;
        end else if (zerar) begin
            r_units   <= 4'd0;
            r_tens    <= 4'd0;
            r_estouro <= 1'b0;
        end else begin
            r_units   <= w_units_nx;
            r_tens    <= w_tens_nx;
            r_estouro <= w_wrap;
        end
    end

    assign saida   = {r_tens, r_units};
    assign estouro = r_estouro;

endmodule

// File: doc/placar_bcd.md
PLACAR_BCD -- requirements
Module: placar_bcd

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 500000, sets the consecutive stable cycles needed to accept a button level (10 ms at 50 MHz); legal range >= 2.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 btn_inc_n  input  1  raw push button, active-low, asynchronous to clk; a press increments the score.
REQ-005 btn_dec_n  input  1  raw push button, active-low, asynchronous to clk; a press decrements the score.
REQ-006 zerar  input  1  synchronous clear, active-high, already synchronous to clk.
REQ-007 saida  output  8  packed BCD score, tens in [7:4] and units in [3:0]; feeds the two-digit 7-segment display stage directly.
REQ-008 estouro  output  1  one-cycle pulse when an increment wraps 99 to 00.

Function
REQ-009 Each button SHALL pass through its own two-flop synchronizer before any other logic.
REQ-010 Each button SHALL have its own debouncer with a stable level register and a counter of width clog2(DEBOUNCE_CICLOS).
REQ-011 Debouncer: synchronized level equal to stable level -> counter cleared to 0.
REQ-012 Debouncer: synchronized level different from stable level -> counter increments; when the counter reaches DEBOUNCE_CICLOS-1, the stable level takes the synchronized level and the counter clears.
REQ-013 A press event SHALL be a one-cycle registered pulse generated when the stable level goes from 1 to 0; a release (0 to 1) generates no event.
REQ-014 Latency: with a button held low, saida SHALL change exactly DEBOUNCE_CICLOS+3 rising edges after the first edge that samples the low level in the first synchronizer flop.
REQ-015 Any low or high glitch shorter than DEBOUNCE_CICLOS synchronized cycles SHALL not change the stable level and SHALL not generate an event.
REQ-016 Increment, units < 9: units +1.
REQ-017 Increment, units = 9 and tens < 9: units = 0, tens +1.
REQ-018 Increment at 99: saida = 00, and estouro is high for exactly the cycle in which saida shows 00.
REQ-019 Decrement, units > 0: units -1.
REQ-020 Decrement, units = 0 and tens > 0: units = 9, tens -1.
REQ-021 Decrement at 00: saturates; saida stays 00 and estouro stays 0.
REQ-022 saida SHALL never hold a nibble greater than 9.
REQ-023 Increment and decrement events in the same cycle SHALL cancel: saida unchanged, estouro 0.
REQ-024 zerar SHALL have priority over all events: the next edge sets saida = 00 and estouro = 0, and any pending events in that cycle are discarded.
REQ-025 zerar SHALL NOT affect the synchronizers or debouncers.
REQ-026 One held press SHALL produce exactly one event, with no auto-repeat.
REQ-027 estouro is 0 in every cycle not covered by REQ-018.
REQ-028 saida and estouro SHALL be driven directly from flops.

Reset
REQ-029 While rst_n = 0, independent of clk: saida = 8'h00, estouro = 0, synchronizer flops = 1, stable levels = 1 (released), debounce counters = 0, event pulses = 0.
REQ-030 Reset asserted mid-debounce or mid-press SHALL discard that press.
REQ-031 After rst_n deasserts with a button already held low, that press SHALL be accepted once, following REQ-014 timing.

Verification (DEBOUNCE_CICLOS = 4 in simulation)
REQ-032 Clean press: btn_inc_n held low 20 cycles from reset -> saida goes 00 to 01 exactly 7 edges after the first low sample; release causes no further change.
REQ-033 Bounce: btn_inc_n low 3 cycles, high 2, low 3, then high -> saida stays 00 and no event is generated.
REQ-034 Carry and wrap: preload 09 by presses, one increment -> 10; from 99, one increment -> 00 with estouro high for 1 cycle only.
REQ-035 Decrement: from 10, decrement -> 09; from 00, decrement -> 00 with estouro 0.
REQ-036 Simultaneous and clear: both buttons produce events in the same cycle at 42 -> saida stays 42; zerar coincident with an increment event at 42 -> saida becomes 00.
REQ-037 Reset mid-operation: rst_n pulsed low with saida = 57 while btn_dec_n is held for 2 cycles -> saida = 00 immediately (asynchronous), and after release of reset the held button yields exactly one decrement attempt, leaving saida at 00 (saturated).
